// File: rtl/cv32e40p_apu_resp_pkg.sv
// cv32e40p_apu_resp_pkg
//   Shared types for the APU responder: the operation encoding seen on the
//   core/FPU interface, the latency-class decode and one delay-line slot.
//   No ports (package).
package cv32e40p_apu_resp_pkg;

  localparam int APU_FLAGS_W    = 5;   // fflags NV,DZ,OF,UF,NX
  localparam int APU_OP_W       = 6;
  localparam int APU_IN_FLAGS_W = 15;  // rounding mode / format fields

  typedef enum logic [APU_OP_W-1:0] {
    APU_FADD     = 6'd0,
    APU_FSUB     = 6'd1,
    APU_FMUL     = 6'd2,
    APU_FMADD    = 6'd3,
    APU_FMSUB    = 6'd4,
    APU_FNMSUB   = 6'd5,
    APU_FNMADD   = 6'd6,
    APU_FDIV     = 6'd7,
    APU_FSQRT    = 6'd8,
    APU_FMIN     = 6'd9,
    APU_FMAX     = 6'd10,
    APU_FCMP     = 6'd11,
    APU_FCVT_F2I = 6'd12,
    APU_FCVT_I2F = 6'd13,
    APU_FSGNJ    = 6'd14,
    APU_FCLASS   = 6'd15
  } apu_op_e;

  typedef struct packed {
    logic                   valid;
    logic [31:0]            result;
    logic [APU_FLAGS_W-1:0] flags;
  } apu_slot_t;

  // Add/sub/mul/fused-multiply-add class; every other code (including
  // unassigned encodings) takes the "others" latency.
  function automatic logic op_is_addmul(input logic [APU_OP_W-1:0] op);
    case (op)
      APU_FADD, APU_FSUB, APU_FMUL,
      APU_FMADD, APU_FMSUB, APU_FNMSUB, APU_FNMADD: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cv32e40p_apu_delay_line.sv
// cv32e40p_apu_delay_line
//   Result delay line with slots 0..MAX_LAT. Slot 0 is the visible output
//   stage; every cycle slot k takes slot k+1 and the top slot refills with
//   an all-zero (invalid) entry, so an entry written into slot L appears at
//   the head L+1 cycles later and invalid slots always carry zero data.
//   A write overrides the shift for the selected slot.
// Ports
//   clk_i, rst_i  clock, asynchronous active-high reset
//   wr_sel_i      one-hot (or zero) write select, bit k = write slot k
//   wr_slot_i     entry to write
//   head_o        slot 0 contents
//   valid_o       per-slot valid bits (current occupancy)
module cv32e40p_apu_delay_line
  import cv32e40p_apu_resp_pkg::*;
#(
  parameter int MAX_LAT = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [MAX_LAT:0] wr_sel_i,
  input  apu_slot_t        wr_slot_i,
  output apu_slot_t        head_o,
  output logic [MAX_LAT:0] valid_o
);

  for (genvar gi = 0; gi <= MAX_LAT; gi++) begin : g_slot
    apu_slot_t r_slot;
    apu_slot_t w_shift_in;

    if (gi == MAX_LAT) begin : g_top
      assign w_shift_in = '0;
    end else begin : g_mid
      assign w_shift_in = g_slot[gi+1].r_slot;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_slot <= '0;
      end else if (wr_sel_i[gi]) begin
        r_slot <= wr_slot_i;
      end else begin
        r_slot <= w_shift_in;
      end
    end

    assign valid_o[gi] = r_slot.valid;
  end

  assign head_o = g_slot[0].r_slot;

endmodule

// File: rtl/cv32e40p_apu_responder.sv
// cv32e40p_apu_responder
//   FPU-side end of the core APU interface. Grants requests, forwards them
//   to a combinational FP datapath, delays each result by its class latency
//   and returns results strictly in order as a one-cycle apu_rvalid_o pulse.
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   apu_req_i/op/operands/flags   core request (held until granted)
//   apu_gnt_o              combinational grant
//   apu_rvalid_o/result/rflags    registered result return
//   fu_valid_o/op/operands/flags  request forwarded to the datapath
//   fu_result_i/status_i   combinational datapath answer
//   stall_cnt_o, op_cnt_o  only with CV32E40P_APU_RESP_PERF_EN defined:
//                          saturating counts of stalled cycles / handshakes
module cv32e40p_apu_responder
  import cv32e40p_apu_resp_pkg::*;
#(
  parameter int ADDMUL_LAT = 0,
  parameter int OTHERS_LAT = 0,
  parameter int MAX_LAT    = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      apu_req_i,
  input  logic [APU_OP_W-1:0]       apu_op_i,
  input  logic [2:0][31:0]          apu_operands_i,
  input  logic [APU_IN_FLAGS_W-1:0] apu_flags_i,
  output logic                      apu_gnt_o,
  output logic                      apu_rvalid_o,
  output logic [31:0]               apu_result_o,
  output logic [APU_FLAGS_W-1:0]    apu_rflags_o,
  output logic                      fu_valid_o,
  output logic [APU_OP_W-1:0]       fu_op_o,
  output logic [2:0][31:0]          fu_operands_o,
  output logic [APU_IN_FLAGS_W-1:0] fu_flags_o,
  input  logic [31:0]               fu_result_i,
  input  logic [APU_FLAGS_W-1:0]    fu_status_i
`ifdef CV32E40P_APU_RESP_PERF_EN
  ,
  output logic [31:0]               stall_cnt_o,
  output logic [31:0]               op_cnt_o
`endif
);

  if (ADDMUL_LAT < 0 || ADDMUL_LAT > MAX_LAT ||
      OTHERS_LAT < 0 || OTHERS_LAT > MAX_LAT) begin : g_lat_check
    $error("cv32e40p_apu_responder: latency outside 0..MAX_LAT");
  end

  localparam logic [MAX_LAT:0] SLOT_ONE = (MAX_LAT+1)'(1);

  int               w_lat;
  logic [MAX_LAT:0] w_valid;
  logic             w_block;
  logic             w_handshake;
  logic [MAX_LAT:0] w_wr_sel;
  apu_slot_t        w_wr_slot;
  apu_slot_t        w_head;

  always_comb begin
    w_lat = op_is_addmul(apu_op_i) ? ADDMUL_LAT : OTHERS_LAT;
  end

  // An entry now in slot k returns k cycles from now; a new op returns
  // L+1 cycles from now. Blocking every occupied slot above L keeps returns
  // strictly ordered and collision-free, while slot L+1 itself would return
  // in the same cycle as the new op, hence it blocks too.
  assign w_block     = |(w_valid >> (w_lat + 1));
  assign apu_gnt_o   = apu_req_i & ~w_block;
  assign w_handshake = apu_gnt_o;

  assign w_wr_sel  = w_handshake ? (SLOT_ONE << w_lat) : '0;
  assign w_wr_slot = '{valid: 1'b1, result: fu_result_i, flags: fu_status_i};

  cv32e40p_apu_delay_line #(
    .MAX_LAT (MAX_LAT)
  ) u_delay_line (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_sel_i  (w_wr_sel),
    .wr_slot_i (w_wr_slot),
    .head_o    (w_head),
    .valid_o   (w_valid)
  );

  // Slot 0 is the registered output stage; invalid slots hold zero data.
  assign apu_rvalid_o = w_head.valid;
  assign apu_result_o = w_head.result;
  assign apu_rflags_o = w_head.flags;

  assign fu_valid_o    = w_handshake;
  assign fu_op_o       = apu_op_i;
  assign fu_operands_o = apu_operands_i;
  assign fu_flags_o    = apu_flags_i;

`ifdef CV32E40P_APU_RESP_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_op_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_op_cnt    <= '0;
    end else begin
      if (apu_req_i && !apu_gnt_o && r_stall_cnt != 32'hFFFF_FFFF) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_handshake && r_op_cnt != 32'hFFFF_FFFF) begin
        r_op_cnt <= r_op_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign op_cnt_o    = r_op_cnt;
`endif

endmodule

// File: tb/tb_cv32e40p_apu_responder.sv
// Bench for cv32e40p_apu_responder: three instances with latency
// configurations (0/0), (2/0) and (0/3) share op/operand/flag stimulus;
// each has its own request and datapath answer, and only one is active
// at a time.
module tb_cv32e40p_apu_responder;
  import cv32e40p_apu_resp_pkg::*;

  logic clk;
  logic rst;

  logic [APU_OP_W-1:0]       op;
  logic [2:0][31:0]          operands;
  logic [APU_IN_FLAGS_W-1:0] flags;

  logic [2:0]                req;
  logic [2:0]                gnt;
  logic [2:0]                rvalid;
  logic [2:0]                fu_valid;
  logic [31:0]               result   [3];
  logic [APU_FLAGS_W-1:0]    rflags   [3];
  logic [APU_OP_W-1:0]       fu_op    [3];
  logic [2:0][31:0]          fu_opnds [3];
  logic [APU_IN_FLAGS_W-1:0] fu_flags [3];
  logic [31:0]               fu_res   [3];
  logic [APU_FLAGS_W-1:0]    fu_st    [3];
`ifdef CV32E40P_APU_RESP_PERF_EN
  logic [31:0]               stall_cnt [3];
  logic [31:0]               op_cnt    [3];
`endif

  int n_total = 0;
  int n_pass  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    cv32e40p_apu_responder #(
      .ADDMUL_LAT (gi == 1 ? 2 : 0),
      .OTHERS_LAT (gi == 2 ? 3 : 0),
      .MAX_LAT    (3)
    ) u_dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .apu_req_i      (req[gi]),
      .apu_op_i       (op),
      .apu_operands_i (operands),
      .apu_flags_i    (flags),
      .apu_gnt_o      (gnt[gi]),
      .apu_rvalid_o   (rvalid[gi]),
      .apu_result_o   (result[gi]),
      .apu_rflags_o   (rflags[gi]),
      .fu_valid_o     (fu_valid[gi]),
      .fu_op_o        (fu_op[gi]),
      .fu_operands_o  (fu_opnds[gi]),
      .fu_flags_o     (fu_flags[gi]),
      .fu_result_i    (fu_res[gi]),
      .fu_status_i    (fu_st[gi])
`ifdef CV32E40P_APU_RESP_PERF_EN
      ,
      .stall_cnt_o    (stall_cnt[gi]),
      .op_cnt_o       (op_cnt[gi])
`endif
    );
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one request onto instance d with its datapath answer.
  task automatic drive(input int d, input apu_op_e o, input logic [31:0] r, input logic [4:0] s);
    req[d]   = 1'b1;
    op       = o;
    fu_res[d] = r;
    fu_st[d]  = s;
  endtask

  typedef struct {
    apu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [14:0] fl;
    logic [31:0] res;
    logic [4:0]  st;
  } vec_t;

  localparam int NV = 6;
  vec_t vt [NV];

  initial begin
    vt[0] = '{APU_FADD, 32'h3F00_0000, 32'h3F00_0000, 32'h0, 15'h0001, 32'h3F80_0000, 5'b00001};
    vt[1] = '{APU_FADD, 32'h4000_0000, 32'h4040_0000, 32'h0, 15'h0002, 32'h40A0_0000, 5'b00000};
    vt[2] = '{APU_FADD, 32'h1111_1111, 32'h2222_2222, 32'h3, 15'h7FFF, 32'hDEAD_BEEF, 5'b10000};
    vt[3] = '{APU_FADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h4, 15'h4000, 32'h0000_0000, 5'b00101};
    vt[4] = '{APU_FDIV, 32'h4080_0000, 32'h4000_0000, 32'h5, 15'h0100, 32'h4000_0000, 5'b01000};
    vt[5] = '{APU_FMIN, 32'hBF80_0000, 32'h3F80_0000, 32'h6, 15'h0003, 32'hBF80_0000, 5'b00010};

    rst      = 1'b1;
    req      = '0;
    op       = APU_FADD;
    operands = '0;
    flags    = '0;
    for (int d = 0; d < 3; d++) begin
      fu_res[d] = '0;
      fu_st[d]  = '0;
    end

    // Reset state
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_rvalid%0d", d), 96'(rvalid[d]), 96'(0));
      chk($sformatf("reset_result%0d", d), 96'(result[d]), 96'(0));
      chk($sformatf("reset_rflags%0d", d), 96'(rflags[d]), 96'(0));
      chk($sformatf("reset_gnt%0d", d),    96'(gnt[d]),    96'(0));
    end
    rst = 1'b0;

    // Zero-latency instance: table vectors issued back to back, each result
    // expected in the very next cycle.
    for (int i = 0; i <= NV; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("t1_rvalid[%0d]", i-1), 96'(rvalid[0]), 96'(1));
        chk($sformatf("t1_result[%0d]", i-1), 96'(result[0]), 96'(vt[i-1].res));
        chk($sformatf("t1_rflags[%0d]", i-1), 96'(rflags[0]), 96'(vt[i-1].st));
      end else begin
        chk("t1_rvalid_idle", 96'(rvalid[0]), 96'(0));
      end
      if (i < NV) begin
        drive(0, vt[i].op, vt[i].res, vt[i].st);
        operands = {vt[i].c, vt[i].b, vt[i].a};
        flags    = vt[i].fl;
        #1;
        chk($sformatf("t1_gnt[%0d]", i),      96'(gnt[0]),      96'(1));
        chk($sformatf("t1_fu_valid[%0d]", i), 96'(fu_valid[0]), 96'(1));
        chk($sformatf("t1_fu_op[%0d]", i),    96'(fu_op[0]),    96'(vt[i].op));
        chk($sformatf("t1_fu_opnds[%0d]", i), 96'(fu_opnds[0]), {vt[i].c, vt[i].b, vt[i].a});
        chk($sformatf("t1_fu_flags[%0d]", i), 96'(fu_flags[0]), 96'(vt[i].fl));
      end else begin
        req[0] = 1'b0;
        #1;
        chk("t1_idle_gnt",      96'(gnt[0]),      96'(0));
        chk("t1_idle_fu_valid", 96'(fu_valid[0]), 96'(0));
      end
    end
    @(negedge clk);
    chk("t1_rvalid_after", 96'(rvalid[0]), 96'(0));

    // OTHERS_LAT=3: FDIV then FADD; FADD stalls until FDIV sits in the
    // output stage, then the two return on consecutive cycles.
    @(negedge clk);
    drive(2, APU_FDIV, 32'hAAAA_0001, 5'b01000);
    #1 chk("t3_gnt_div", 96'(gnt[2]), 96'(1));
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("t3_rvalid_c%0d", c), 96'(rvalid[2]), 96'(0));
      drive(2, APU_FADD, 32'hBBBB_0002, 5'b00001);
      #1 chk($sformatf("t3_gnt_add_c%0d", c), 96'(gnt[2]), 96'(0));
    end
    @(negedge clk);
    chk("t3_rvalid_div", 96'(rvalid[2]), 96'(1));
    chk("t3_result_div", 96'(result[2]), 96'(32'hAAAA_0001));
    chk("t3_rflags_div", 96'(rflags[2]), 96'(5'b01000));
    #1 chk("t3_gnt_add_c4", 96'(gnt[2]), 96'(1));
    @(negedge clk);
    chk("t3_rvalid_add", 96'(rvalid[2]), 96'(1));
    chk("t3_result_add", 96'(result[2]), 96'(32'hBBBB_0002));
    chk("t3_rflags_add", 96'(rflags[2]), 96'(5'b00001));
    req[2] = 1'b0;
    @(negedge clk);
    chk("t3_rvalid_end", 96'(rvalid[2]), 96'(0));
`ifdef CV32E40P_APU_RESP_PERF_EN
    chk("t6_stall_cnt", 96'(stall_cnt[2]), 96'(3));
    chk("t6_op_cnt",    96'(op_cnt[2]),    96'(2));
`endif

    // ADDMUL_LAT=2: FMUL then FMIN; FMIN granted once FMUL is in the
    // output stage, results return on two consecutive cycles.
    @(negedge clk);
    drive(1, APU_FMUL, 32'h1234_5678, 5'b00100);
    #1 chk("t2_gnt_mul", 96'(gnt[1]), 96'(1));
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk($sformatf("t2_rvalid_c%0d", c), 96'(rvalid[1]), 96'(0));
      drive(1, APU_FMIN, 32'h8765_4321, 5'b10000);
      #1 chk($sformatf("t2_gnt_min_c%0d", c), 96'(gnt[1]), 96'(0));
    end
    @(negedge clk);
    chk("t2_rvalid_mul", 96'(rvalid[1]), 96'(1));
    chk("t2_result_mul", 96'(result[1]), 96'(32'h1234_5678));
    #1 chk("t2_gnt_min_c3", 96'(gnt[1]), 96'(1));
    @(negedge clk);
    chk("t2_rvalid_min", 96'(rvalid[1]), 96'(1));
    chk("t2_result_min", 96'(result[1]), 96'(32'h8765_4321));
    chk("t2_rflags_min", 96'(rflags[1]), 96'(5'b10000));
    req[1] = 1'b0;
    @(negedge clk);
    chk("t2_rvalid_end", 96'(rvalid[1]), 96'(0));

    // Same-latency back-to-back FMULs: granted every cycle.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(1, APU_FMUL, 32'h0000_0100 + 32'(c), 5'(c));
      #1 chk($sformatf("t2b_gnt%0d", c), 96'(gnt[1]), 96'(1));
    end
    @(negedge clk);
    req[1] = 1'b0;
    chk("t2b_rvalid_early", 96'(rvalid[1]), 96'(0));
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("t2b_rvalid%0d", c), 96'(rvalid[1]), 96'(1));
      chk($sformatf("t2b_result%0d", c), 96'(result[1]), 96'(32'h0000_0100 + 32'(c)));
    end
    @(negedge clk);
    chk("t2b_rvalid_end", 96'(rvalid[1]), 96'(0));

    // Reset one cycle after a latency-2 issue: the result is discarded.
    @(negedge clk);
    drive(1, APU_FMUL, 32'hCAFE_F00D, 5'b11111);
    #1 chk("t5_gnt", 96'(gnt[1]), 96'(1));
    @(negedge clk);
    req[1] = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      chk($sformatf("t5_rvalid_c%0d", c), 96'(rvalid[1]), 96'(0));
      chk($sformatf("t5_result_c%0d", c), 96'(result[1]), 96'(0));
      chk($sformatf("t5_rflags_c%0d", c), 96'(rflags[1]), 96'(0));
      @(negedge clk);
    end
`ifdef CV32E40P_APU_RESP_PERF_EN
    chk("t6_stall_cnt_rst", 96'(stall_cnt[2]), 96'(0));
    chk("t6_op_cnt_rst",    96'(op_cnt[2]),    96'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
